// File: rtl/edge_detector_seq_ctrl.sv
// edge_detector_seq_ctrl
//   Sequencing controller for the edge-detection datapath. It owns all the
//   image, window, result and output counters. A run has four phases:
//   load the image, run the 3x3 kernel over every window, stream the
//   results out, then pulse done. abort_i cancels a run and returns the
//   controller to IDLE.
//
// Ports
//   clk_i, rst_i         clock, asynchronous active-low reset
//   start_i              start request; only its rising edge starts a run
//   abort_i              synchronous abort; ignored while idle
//   in_valid_i           input pixel valid
//   in_ready_o           controller is accepting pixels
//   img_wr_o             image RAM write strobe
//   img_waddr_o          image RAM write address
//   kernel_en_o          kernel engine enable
//   win_row_o            top-left row of the current window
//   win_col_o            top-left column of the current window
//   res_wr_o             result RAM write strobe
//   res_addr_o           result RAM write address
//   out_valid_o          output beat valid
//   out_ready_i          downstream ready
//   out_addr_o           result RAM read address of the current beat
//   out_last_o           current beat is the final beat
//   idle_o               controller is in IDLE
//   done_o               one-cycle completion pulse
module edge_detector_seq_ctrl #(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int KERNEL_LAT = 3,
  parameter int ADDR_W     = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              img_wr_o,
  output logic [ADDR_W-1:0] img_waddr_o,
  output logic              kernel_en_o,
  output logic [ADDR_W-1:0] win_row_o,
  output logic [ADDR_W-1:0] win_col_o,
  output logic              res_wr_o,
  output logic [ADDR_W-1:0] res_addr_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              out_last_o,
  output logic              idle_o,
  output logic              done_o
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int NW   = IMG_W - 2;
  localparam int NWIN = (IMG_W - 2) * (IMG_H - 2);

  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] LAT_LAST = ADDR_W'(KERNEL_LAT - 1);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(NW - 1);
  localparam logic [ADDR_W-1:0] WIN_LAST = ADDR_W'(NWIN - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    STORE,
    OUTPUT,
    DONE
  } state_t;

  state_t            state;
  logic              start_q;
  logic [ADDR_W-1:0] pix_cnt;
  logic [ADDR_W-1:0] lat_cnt;
  logic [ADDR_W-1:0] win_row;
  logic [ADDR_W-1:0] win_col;
  logic [ADDR_W-1:0] res_cnt;
  logic [ADDR_W-1:0] out_cnt;

  // Main sequencer. start_q is sampled every cycle so that only a rising
  // edge of start_i can start a run. Abort is checked first so that it
  // wins over every other transition, including the final output handshake.
  // Each counter stops at its terminal value and does not wrap. The state
  // change is what moves the run to the next phase. Counters are cleared on
  // abort and on completion, so IDLE always holds zeroed counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      start_q <= 1'b0;
      pix_cnt <= '0;
      lat_cnt <= '0;
      win_row <= '0;
      win_col <= '0;
      res_cnt <= '0;
      out_cnt <= '0;
    end else begin
      start_q <= start_i;
      if (abort_i && (state != IDLE)) begin
        state   <= IDLE;
        pix_cnt <= '0;
        lat_cnt <= '0;
        win_row <= '0;
        win_col <= '0;
        res_cnt <= '0;
        out_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i && !start_q) begin
              state   <= LOAD;
              pix_cnt <= '0;
              lat_cnt <= '0;
              win_row <= '0;
              win_col <= '0;
              res_cnt <= '0;
              out_cnt <= '0;
            end
          end
          LOAD: begin
            if (in_valid_i) begin
              if (pix_cnt == PIX_LAST) state <= CALC;
              else                     pix_cnt <= pix_cnt + 1'b1;
            end
          end
          CALC: begin
            if (lat_cnt == LAT_LAST) begin
              lat_cnt <= '0;
              state   <= STORE;
            end else begin
              lat_cnt <= lat_cnt + 1'b1;
            end
          end
          STORE: begin
            // On the final window the window position is left where it is,
            // so that the row counter does not step past the last window row.
            if (res_cnt == WIN_LAST) begin
              state <= OUTPUT;
            end else begin
              state   <= CALC;
              res_cnt <= res_cnt + 1'b1;
              if (win_col == COL_LAST) begin
                win_col <= '0;
                win_row <= win_row + 1'b1;
              end else begin
                win_col <= win_col + 1'b1;
              end
            end
          end
          OUTPUT: begin
            if (out_ready_i) begin
              if (out_cnt == WIN_LAST) state <= DONE;
              else                     out_cnt <= out_cnt + 1'b1;
            end
          end
          DONE: begin
            state   <= IDLE;
            pix_cnt <= '0;
            lat_cnt <= '0;
            win_row <= '0;
            win_col <= '0;
            res_cnt <= '0;
            out_cnt <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Output decode. The outputs depend only on the state and the counters,
  // except img_wr_o, which must mark the same cycle a pixel is accepted.
  // Address outputs are forced to zero outside the state that uses them,
  // so that stale counter values never appear on the buses.
  assign idle_o      = (state == IDLE);
  assign done_o      = (state == DONE);
  assign in_ready_o  = (state == LOAD);
  assign img_wr_o    = (state == LOAD) && in_valid_i;
  assign img_waddr_o = (state == LOAD) ? pix_cnt : '0;
  assign kernel_en_o = (state == CALC);
  assign win_row_o   = ((state == CALC) || (state == STORE)) ? win_row : '0;
  assign win_col_o   = ((state == CALC) || (state == STORE)) ? win_col : '0;
  assign res_wr_o    = (state == STORE);
  assign res_addr_o  = (state == STORE) ? res_cnt : '0;
  assign out_valid_o = (state == OUTPUT);
  assign out_addr_o  = (state == OUTPUT) ? out_cnt : '0;
  assign out_last_o  = (state == OUTPUT) && (out_cnt == WIN_LAST);

endmodule

// File: tb/tb_edge_detector_seq_ctrl.sv
// tb_edge_detector_seq_ctrl
//   Directed bench for edge_detector_seq_ctrl. It uses two instances:
//   dut_a has the default 8x8 image with a 3-cycle kernel, and dut_b has a
//   5x4 image with a 1-cycle kernel. Expected values are worked out by hand
//   from the window ordering: window w is at row w/NW and column w%NW.
module tb_edge_detector_seq_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;

  logic       start_i = 1'b0, abort_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic       in_ready_o, img_wr_o, kernel_en_o, res_wr_o, out_valid_o, out_last_o, idle_o, done_o;
  logic [5:0] img_waddr_o, win_row_o, win_col_o, res_addr_o, out_addr_o;

  logic       b_start = 1'b0, b_abort = 1'b0, b_valid = 1'b0, b_ready = 1'b0;
  logic       b_in_ready, b_img_wr, b_kernel_en, b_res_wr, b_out_valid, b_out_last, b_idle, b_done;
  logic [5:0] b_img_waddr, b_win_row, b_win_col, b_res_addr, b_out_addr;

  int checks = 0;
  int errors = 0;
  logic hold_start = 1'b0;

  always #5 clk_i = ~clk_i;

  edge_detector_seq_ctrl dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .img_wr_o(img_wr_o),
    .img_waddr_o(img_waddr_o), .kernel_en_o(kernel_en_o), .win_row_o(win_row_o),
    .win_col_o(win_col_o), .res_wr_o(res_wr_o), .res_addr_o(res_addr_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_addr_o(out_addr_o),
    .out_last_o(out_last_o), .idle_o(idle_o), .done_o(done_o)
  );

  edge_detector_seq_ctrl #(.IMG_W(5), .IMG_H(4), .KERNEL_LAT(1), .ADDR_W(6)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(b_start), .abort_i(b_abort),
    .in_valid_i(b_valid), .in_ready_o(b_in_ready), .img_wr_o(b_img_wr),
    .img_waddr_o(b_img_waddr), .kernel_en_o(b_kernel_en), .win_row_o(b_win_row),
    .win_col_o(b_win_col), .res_wr_o(b_res_wr), .res_addr_o(b_res_addr),
    .out_valid_o(b_out_valid), .out_ready_i(b_ready), .out_addr_o(b_out_addr),
    .out_last_o(b_out_last), .idle_o(b_idle), .done_o(b_done)
  );

  // Inputs change 2 time units after the rising edge. Outputs are sampled
  // 1 time unit later, so the combinational write strobe has settled.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic vl, input logic rd);
    start_i     = st;
    abort_i     = ab;
    in_valid_i  = vl;
    out_ready_i = rd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Rising edge on start_i. After the next clock edge the controller must
  // be in LOAD and accepting pixels.
  task automatic startRun();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("pre_start_idle", 32'(idle_o), 1);
    tick();
    applyStimulus(hold_start, 1'b0, 1'b0, 1'b1);
    checkOutput("load_in_ready", 32'(in_ready_o), 1);
    checkOutput("load_not_idle", 32'(idle_o), 0);
  endtask

  // Sends 64 pixels. When throttle is set, each pixel follows a gap cycle
  // with in_valid_i low, which must produce no write.
  task automatic loadPixels(input bit throttle);
    for (int i = 0; i < 64; i++) begin
      if (throttle) begin
        applyStimulus(hold_start, 1'b0, 1'b0, 1'b1);
        checkOutput("gap_no_write", 32'(img_wr_o), 0);
        checkOutput("gap_addr_hold", 32'(img_waddr_o), i);
        tick();
      end
      applyStimulus(hold_start, 1'b0, 1'b1, 1'b1);
      checkOutput("img_wr", 32'(img_wr_o), 1);
      checkOutput("img_waddr", 32'(img_waddr_o), i);
      tick();
    end
    applyStimulus(hold_start, 1'b0, 1'b0, 1'b1);
  endtask

  // Steps through windows first..last. Each window is 3 kernel cycles and
  // then 1 store cycle. When pulse is set, start_i rises during window 3,
  // and this edge must be ignored.
  task automatic calcWindows(input int first, input int last, input bit pulse);
    for (int w = first; w <= last; w++) begin
      for (int k = 0; k < 3; k++) begin
        applyStimulus(hold_start | (pulse && w == 3 && k == 0), 1'b0, 1'b0, 1'b1);
        checkOutput("kernel_en", 32'(kernel_en_o), 1);
        checkOutput("win_row", 32'(win_row_o), w / 6);
        checkOutput("win_col", 32'(win_col_o), w % 6);
        tick();
      end
      applyStimulus(hold_start, 1'b0, 1'b0, 1'b1);
      checkOutput("res_wr", 32'(res_wr_o), 1);
      checkOutput("res_addr", 32'(res_addr_o), w);
      checkOutput("store_kernel_off", 32'(kernel_en_o), 0);
      tick();
    end
  endtask

  // Streams output beats 0..lastBeat. The beat numbered stall waits 3
  // cycles with out_ready_i low before it is taken. If the final beat
  // (35) is reached, this task also checks the done pulse and the return
  // to IDLE.
  task automatic outputBeats(input int stall, input int lastBeat);
    for (int b = 0; b <= lastBeat; b++) begin
      if (b == stall) begin
        for (int s = 0; s < 3; s++) begin
          applyStimulus(hold_start, 1'b0, 1'b0, 1'b0);
          checkOutput("stall_valid", 32'(out_valid_o), 1);
          checkOutput("stall_addr", 32'(out_addr_o), b);
          checkOutput("stall_last", 32'(out_last_o), 0);
          tick();
        end
      end
      applyStimulus(hold_start, 1'b0, 1'b0, 1'b1);
      checkOutput("out_valid", 32'(out_valid_o), 1);
      checkOutput("out_addr", 32'(out_addr_o), b);
      checkOutput("out_last", 32'(out_last_o), (b == 35) ? 1 : 0);
      tick();
    end
    if (lastBeat == 35) begin
      applyStimulus(hold_start, 1'b0, 1'b0, 1'b1);
      checkOutput("done_pulse", 32'(done_o), 1);
      checkOutput("done_not_idle", 32'(idle_o), 0);
      tick();
      applyStimulus(hold_start, 1'b0, 1'b0, 1'b1);
      checkOutput("post_done_idle", 32'(idle_o), 1);
      checkOutput("post_done_low", 32'(done_o), 0);
    end
  endtask

  // Directed sequence. Each section picks up where the previous one left
  // the controller.
  initial begin
    // Reset values.
    #3;
    checkOutput("rst_idle", 32'(idle_o), 1);
    checkOutput("rst_in_ready", 32'(in_ready_o), 0);
    checkOutput("rst_kernel_en", 32'(kernel_en_o), 0);
    checkOutput("rst_out_valid", 32'(out_valid_o), 0);
    checkOutput("rst_done", 32'(done_o), 0);
    checkOutput("rst_b_idle", 32'(b_idle), 1);
    checkOutput("rst_b_in_ready", 32'(b_in_ready), 0);
    tick();
    rst_i = 1'b1;
    tick();

    $display("[TB] nominal run");
    startRun();
    loadPixels(1'b0);
    calcWindows(0, 35, 1'b0);
    outputBeats(-1, 35);

    $display("[TB] throttled run with stray start edge in CALC");
    startRun();
    loadPixels(1'b1);
    calcWindows(0, 35, 1'b1);
    outputBeats(10, 35);

    $display("[TB] start held high");
    hold_start = 1'b1;
    startRun();
    loadPixels(1'b0);
    calcWindows(0, 35, 1'b0);
    outputBeats(-1, 35);
    tick();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput("held_start_idle", 32'(idle_o), 1);
      checkOutput("held_start_no_load", 32'(in_ready_o), 0);
      tick();
    end
    hold_start = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    $display("[TB] abort in window 10");
    startRun();
    loadPixels(1'b0);
    calcWindows(0, 9, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("w10_kernel_en", 32'(kernel_en_o), 1);
    checkOutput("w10_row", 32'(win_row_o), 1);
    checkOutput("w10_col", 32'(win_col_o), 4);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("abort_cycle_busy", 32'(kernel_en_o), 1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("abort_idle", 32'(idle_o), 1);
    checkOutput("abort_kernel_off", 32'(kernel_en_o), 0);
    checkOutput("abort_no_done", 32'(done_o), 0);
    checkOutput("abort_no_store", 32'(res_wr_o), 0);
    tick();
    checkOutput("abort_still_no_done", 32'(done_o), 0);
    startRun();
    loadPixels(1'b0);
    calcWindows(0, 35, 1'b0);
    outputBeats(-1, 19);

    $display("[TB] reset at beat 20");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("beat20_addr", 32'(out_addr_o), 20);
    rst_i = 1'b0;
    #1;
    checkOutput("arst_idle", 32'(idle_o), 1);
    checkOutput("arst_out_valid", 32'(out_valid_o), 0);
    checkOutput("arst_out_addr", 32'(out_addr_o), 0);
    checkOutput("arst_out_last", 32'(out_last_o), 0);
    tick();
    rst_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("post_rst_idle", 32'(idle_o), 1);
      checkOutput("post_rst_no_write", 32'(img_wr_o), 0);
      checkOutput("post_rst_no_load", 32'(in_ready_o), 0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] 5x4 image, 1-cycle kernel");
    b_start = 1'b1;
    #1;
    tick();
    b_start = 1'b0;
    b_valid = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      checkOutput("b_in_ready", 32'(b_in_ready), 1);
      checkOutput("b_img_wr", 32'(b_img_wr), 1);
      checkOutput("b_img_waddr", 32'(b_img_waddr), i);
      tick();
      #1;
    end
    b_valid = 1'b0;
    for (int w = 0; w < 6; w++) begin
      checkOutput("b_kernel_en", 32'(b_kernel_en), 1);
      checkOutput("b_win_row", 32'(b_win_row), w / 3);
      checkOutput("b_win_col", 32'(b_win_col), w % 3);
      tick();
      #1;
      checkOutput("b_res_wr", 32'(b_res_wr), 1);
      checkOutput("b_res_addr", 32'(b_res_addr), w);
      tick();
      #1;
    end
    b_ready = 1'b1;
    #1;
    for (int b = 0; b < 6; b++) begin
      checkOutput("b_out_valid", 32'(b_out_valid), 1);
      checkOutput("b_out_addr", 32'(b_out_addr), b);
      checkOutput("b_out_last", 32'(b_out_last), (b == 5) ? 1 : 0);
      tick();
      #1;
    end
    checkOutput("b_done", 32'(b_done), 1);
    tick();
    #1;
    checkOutput("b_idle_after", 32'(b_idle), 1);
    b_abort = 1'b1;
    #1;
    tick();
    #1;
    checkOutput("b_abort_in_idle", 32'(b_idle), 1);
    b_abort = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog. If the directed sequence stalls, this block reports the
  // failure and ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
